dmem_bank: RTL and testbench

Parametrised byte-addressable 32-bit data memory bank for the core's load/store path, replacing the fixed 4K-word, word-only, combinational-read data RAM. The bank adds:

- a valid/ready request channel and a backpressured response channel with one outstanding access;
- byte, halfword and word stores through byte-lane enables;
- sign- or zero-extended sub-word loads;
- error reporting for misaligned, out-of-range and reserved-size accesses.

It sits between the memory stage and the data SRAM.

---
 rtl/dmem_bank.sv | 145 ++++++++++++++
 tb/tb_dmem_bank.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bank.sv
// Byte-addressable 32-bit data memory bank with a valid/ready request channel,
// a backpressured single-entry response register, sub-word access and error reporting.
module dmem_bank #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [31:0] mem [DEPTH];

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             size_bad;
    logic             misaligned;
    logic             out_of_range;
    logic             err;
    logic [3:0]       be;
    logic [31:0]      wr_data;
    logic             wr_en;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;
    logic [31:0]      rsp_data_next;

    // Handshake: a request transfers on a rising edge where rst, req_valid and
    // req_ready are all 1; a response transfers on a rising edge where rsp_valid
    // and rsp_ready are both 1. The response register accepts a new request in
    // the same cycle its current contents drain.
    assign req_ready = rst & (~rsp_valid | rsp_ready);
    assign accept    = req_valid & req_ready;

    assign idx  = req_addr[IDX_W+1:2];
    assign lane = req_addr[1:0];

    // Addresses above the bank are rejected rather than folded back onto it.
    assign size_bad     = (req_size == 2'b11);
    assign misaligned   = ((req_size == SZ_HALF) & lane[0]) |
                          ((req_size == SZ_WORD) & (lane != 2'b00));
    assign out_of_range = (64'(req_addr) >= LIMIT);
    assign err          = size_bad | misaligned | out_of_range;

    always_comb begin
        be      = 4'b0000;
        wr_data = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                be[lane] = 1'b1;
                wr_data  = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                be      = 4'b1111;
                wr_data = req_wdata;
            end
            default: begin
                be      = 4'b0000;
                wr_data = req_wdata;
            end
        endcase
    end

    assign wr_en = accept & req_we & ~err;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Array read is combinational so a load accepted right after a store to
    // the same word sees the freshly written data without bypassing.
    assign rd_word = mem[idx];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        case (req_size)
            SZ_BYTE: load_data = req_unsigned ? {24'h0, rd_byte}
                                              : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: load_data = req_unsigned ? {16'h0, rd_half}
                                              : {{16{rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    assign rsp_data_next = (err | req_we) ? 32'h0 : load_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_data_next;
            rsp_err   <= err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_bank.sv
// Directed bench for dmem_bank: vector table for functional and error cases,
// hand-written sequences for backpressure, reset and streaming.
module tb_dmem_bank;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SR = 2'b11;
    localparam int         NV = 25;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [32:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        vecs[NV];

    dmem_bank #(.DEPTH(4096), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one request, waits (bounded) for acceptance and queues the expected response.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, output int waits);
        logic ok;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        waits        = 0;
        @(negedge clk);
        while (!req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        ok = req_ready;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_timeout: addr %h not accepted within 50 cycles", addr);
        end else begin
            exp_q.push_back({exp_err, exp_rd});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (ok) chk("rsp_valid_after_accept", {31'h0, rsp_valid}, 32'h1);
    endtask

    // Scoreboard: every consumed response is matched against the oldest expectation.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rdata %h err %b with nothing expected", rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e[31:0]);
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
            end
        end
    end

    function automatic logic [31:0] ext(input logic [1:0] size, input logic uns, input logic [31:0] d);
        case (size)
            SB:      return uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            SH:      return uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    initial begin
        int w;
        int total_w;
        logic [1:0]  sz;
        logic [1:0]  ln;
        logic        un;
        logic [31:0] ad;
        logic [31:0] dt;

        vecs[0]  = '{1'b1, 32'h0000_0010, SW, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, SW, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0011, SB, 1'b0, 32'h0000_005A, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0012, SH, 1'b0, 32'h0000_8001, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0010, SW, 1'b0, 32'h0,         32'h8001_5AEF, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0012, SH, 1'b0, 32'h0,         32'hFFFF_8001, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0012, SH, 1'b1, 32'h0,         32'h0000_8001, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0013, SB, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0013, SB, 1'b1, 32'h0,         32'h0000_0080, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0011, SB, 1'b0, 32'h0,         32'h0000_005A, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0000, SW, 1'b0, 32'h0102_0304, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0002, SW, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_0001, SH, 1'b0, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
        vecs[13] = '{1'b0, 32'h0000_0000, SW, 1'b0, 32'h0,         32'h0102_0304, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_4000, SW, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
        vecs[15] = '{1'b0, 32'h0000_0010, SR, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
        vecs[16] = '{1'b1, 32'h0000_3FFC, SW, 1'b0, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b0, 32'h0000_3FFC, SW, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[18] = '{1'b1, 32'h0000_4000, SB, 1'b0, 32'h0000_0077, 32'h0000_0000, 1'b1};
        vecs[19] = '{1'b0, 32'h0000_3FFE, SH, 1'b1, 32'h0,         32'h0000_CAFE, 1'b0};
        vecs[20] = '{1'b1, 32'h8000_0010, SW, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[21] = '{1'b0, 32'h0000_0010, SW, 1'b0, 32'h0,         32'h8001_5AEF, 1'b0};
        vecs[22] = '{1'b0, 32'h0000_0011, SH, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
        vecs[23] = '{1'b0, 32'h0000_0010, SH, 1'b0, 32'h0,         32'h0000_5AEF, 1'b0};
        vecs[24] = '{1'b0, 32'h0000_0010, SB, 1'b0, 32'h0,         32'hFFFF_FFEF, 1'b0};

        // Reset state, with a store presented that must not be taken.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SW;
        idle(3);
        @(negedge clk);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h0);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Vector table, back to back with the consumer always ready.
        total_w = 0;
        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                   vecs[i].rdata, vecs[i].err, w);
            total_w += w;
        end
        chk("table_stalls", total_w, 32'h0);
        idle(2);

        // Backpressure: first response must hold while later requests wait.
        rsp_ready = 1'b0;
        do_req(1'b0, 32'h10, SW, 1'b0, 32'h0, 32'h8001_5AEF, 1'b0, w);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h3FFC;
        req_size     = SW;
        req_unsigned = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
            chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("stall_rsp_rdata", rsp_rdata, 32'h8001_5AEF);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        do_req(1'b0, 32'h3FFC, SW, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, w);
        do_req(1'b0, 32'h13, SB, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, w);
        idle(2);

        // Reset mid-operation drops the pending response and blocks stores.
        do_req(1'b1, 32'h20, SW, 1'b0, 32'h1122_3344, 32'h0, 1'b0, w);
        idle(1);
        rsp_ready = 1'b0;
        do_req(1'b0, 32'h10, SW, 1'b0, 32'h0, 32'h8001_5AEF, 1'b0, w);
        rst       = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_size  = SW;
        req_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("midrst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
        exp_q.delete();
        idle(2);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        do_req(1'b0, 32'h20, SW, 1'b0, 32'h0, 32'h1122_3344, 1'b0, w);
        chk("post_reset_stalls", w, 32'h0);

        // Streaming store/load pairs at one access per cycle.
        total_w = 0;
        for (int p = 0; p < 64; p++) begin
            sz = 2'($urandom_range(0, 2));
            un = 1'($urandom_range(0, 1));
            dt = $urandom;
            ln = (sz == SB) ? 2'($urandom_range(0, 3)) : (sz == SH) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            ad = {18'h0, 12'($urandom_range(0, 4095)), ln};
            do_req(1'b1, ad, sz, 1'b0, dt, 32'h0, 1'b0, w);
            total_w += w;
            do_req(1'b0, ad, sz, un, 32'h0, ext(sz, un, dt), 1'b0, w);
            total_w += w;
        end
        chk("stream_stalls", total_w, 32'h0);

        idle(4);
        chk("exp_q_empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
